// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage MIPS pipeline: widths, special registers,
// control-bundle bit positions and forwarding-select encodings.
package cpu_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [4:0] REG_RA  = 5'd31;
  localparam logic [4:0] REG_SYS = 5'd2;

  localparam int CTL_REGWRITE = 0;
  localparam int CTL_MEMREAD  = 1;
  localparam int CTL_MEMWRITE = 2;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_e;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Forwarding-select for one EX operand: picks EX/MEM over MEM/WB, and never
// forwards for register 0 or an empty (bubble) EX slot.
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int AW = cpu_pkg::AW
) (
  input  logic          valid,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] mem_rw,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] wb_rw,
  input  logic          wb_regwrite,
  output logic [1:0]    sel
);

  always_comb begin
    // NOTE: default assigned first so every path drives sel; no latch inferred.
    sel = FWD_NONE;
    if (valid && src != '0) begin
      if (mem_regwrite && mem_rw == src)
        sel = FWD_MEM;
      else if (wb_regwrite && wb_rw == src)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion and EX forwarding selects.
// Optional: define BUBBLE_CNT_EN to add the saturating bubble_cnt output.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [AW-1:0] id_ra,
  input  logic [AW-1:0] id_rb,
  input  logic [AW-1:0] id_rw,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_r1,
  input  logic [DW-1:0] id_r2,
  input  logic [15:0]   id_ctrl,
  input  logic [AW-1:0] mem_rw,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] wb_rw,
  input  logic          wb_regwrite,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_r1,
  output logic [DW-1:0] ex_r2,
  output logic [AW-1:0] ex_ra,
  output logic [AW-1:0] ex_rb,
  output logic [AW-1:0] ex_rw,
  output logic [15:0]   ex_ctrl,
`ifdef BUBBLE_CNT_EN
  output logic [15:0]   bubble_cnt,
`endif
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  logic bubble;

  // A load in EX whose destination is read by decode cannot be forwarded in time.
  assign stall = id_valid && ex_valid && ex_ctrl[CTL_MEMREAD] && (ex_rw != '0) &&
                 ((id_ra == ex_rw) || (id_rb == ex_rw)) && !flush && !halt;

  assign bubble = (flush || stall) && !halt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset clears the stage immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_r1    <= '0;
      ex_r2    <= '0;
      ex_ra    <= '0;
      ex_rb    <= '0;
      ex_rw    <= '0;
      ex_ctrl  <= '0;
    end else if (halt) begin
      ex_valid <= ex_valid;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_r1    <= '0;
      ex_r2    <= '0;
      ex_ra    <= '0;
      ex_rb    <= '0;
      ex_rw    <= '0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_imm   <= id_imm;
      ex_r1    <= id_r1;
      ex_r2    <= id_r2;
      ex_ra    <= id_ra;
      ex_rb    <= id_rb;
      ex_rw    <= id_rw;
      ex_ctrl  <= id_valid ? id_ctrl : 16'h0000;
    end
  end

`ifdef BUBBLE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= '0;
    else if (bubble && bubble_cnt != 16'hFFFF)
      bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif

  fwd_sel #(.AW(AW)) u_fwd_a (
    .valid        (ex_valid),
    .src          (ex_ra),
    .mem_rw       (mem_rw),
    .mem_regwrite (mem_regwrite),
    .wb_rw        (wb_rw),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_a)
  );

  fwd_sel #(.AW(AW)) u_fwd_b (
    .valid        (ex_valid),
    .src          (ex_rb),
    .mem_rw       (mem_rw),
    .mem_regwrite (mem_regwrite),
    .wb_rw        (wb_rw),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_b)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus random traffic
// checked against a behavioural model of the stage.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          halt = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [DW-1:0] id_pc = '0, id_imm = '0, id_r1 = '0, id_r2 = '0;
  logic [AW-1:0] id_ra = '0, id_rb = '0, id_rw = '0, mem_rw = '0, wb_rw = '0;
  logic [15:0]   id_ctrl = '0;
  logic          mem_regwrite = 1'b0, wb_regwrite = 1'b0;
  logic          stall, ex_valid;
  logic [DW-1:0] ex_pc, ex_imm, ex_r1, ex_r2;
  logic [AW-1:0] ex_ra, ex_rb, ex_rw;
  logic [15:0]   ex_ctrl;
  logic [1:0]    fwd_a, fwd_b;
`ifdef BUBBLE_CNT_EN
  logic [15:0]   bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_ra(id_ra), .id_rb(id_rb), .id_rw(id_rw), .id_imm(id_imm),
    .id_r1(id_r1), .id_r2(id_r2), .id_ctrl(id_ctrl),
    .mem_rw(mem_rw), .mem_regwrite(mem_regwrite), .wb_rw(wb_rw), .wb_regwrite(wb_regwrite),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rw(ex_rw),
    .ex_ctrl(ex_ctrl),
`ifdef BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef struct {
    logic rst, halt, flush, valid;
    logic [DW-1:0] pc, imm, r1, r2;
    logic [AW-1:0] ra, rb, rw, mem_rw, wb_rw;
    logic [15:0] ctrl;
    logic mem_regwrite, wb_regwrite;
  } stim_t;

  typedef struct {
    logic valid;
    logic [DW-1:0] pc, imm, r1, r2;
    logic [AW-1:0] ra, rb, rw;
    logic [15:0] ctrl;
  } state_t;

  typedef struct {
    state_t s;
    logic stall;
    logic [1:0] fa, fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t   sb[$];
  state_t m;
  logic [15:0] mcnt;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic state_t empty_state();
    state_t z;
    z.valid = 1'b0; z.pc = '0; z.imm = '0; z.r1 = '0; z.r2 = '0;
    z.ra = '0; z.rb = '0; z.rw = '0; z.ctrl = '0;
    return z;
  endfunction

  function automatic logic [1:0] fwd_model(input logic v, input logic [AW-1:0] src, input stim_t t);
    if (!v) return 2'b00;
    if (t.mem_regwrite && t.mem_rw != 0 && t.mem_rw == src) return 2'b01;
    if (t.wb_regwrite && t.wb_rw != 0 && t.wb_rw == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic stim_t nop();
    stim_t t;
    t.rst = 0; t.halt = 0; t.flush = 0; t.valid = 0;
    t.pc = '0; t.imm = '0; t.r1 = '0; t.r2 = '0;
    t.ra = '0; t.rb = '0; t.rw = '0; t.mem_rw = '0; t.wb_rw = '0;
    t.ctrl = '0; t.mem_regwrite = 0; t.wb_regwrite = 0;
    return t;
  endfunction

  function automatic stim_t rand_stim();
    stim_t t = nop();
    t.rst          = ($urandom_range(0, 99) == 0);
    t.halt         = ($urandom_range(0, 9) == 0);
    t.flush        = ($urandom_range(0, 9) == 0);
    t.valid        = ($urandom_range(0, 4) != 0);
    t.pc           = $urandom;
    t.imm          = $urandom;
    t.r1           = $urandom;
    t.r2           = $urandom;
    t.ra           = AW'($urandom_range(0, 3));
    t.rb           = AW'($urandom_range(0, 3));
    t.rw           = AW'($urandom_range(0, 3));
    t.ctrl         = 16'($urandom);
    t.mem_rw       = AW'($urandom_range(0, 3));
    t.wb_rw        = AW'($urandom_range(0, 3));
    t.mem_regwrite = $urandom_range(0, 1) == 1;
    t.wb_regwrite  = $urandom_range(0, 1) == 1;
    return t;
  endfunction

  // One cycle of stimulus: drive away from the edge, predict the outputs visible
  // for the rest of this cycle, then advance the model to the next edge.
  task automatic step(input stim_t t);
    exp_t e;
    logic hazard;
    @(posedge clk);
    #1;
    rst = t.rst; halt = t.halt; flush = t.flush; id_valid = t.valid;
    id_pc = t.pc; id_imm = t.imm; id_r1 = t.r1; id_r2 = t.r2;
    id_ra = t.ra; id_rb = t.rb; id_rw = t.rw; id_ctrl = t.ctrl;
    mem_rw = t.mem_rw; wb_rw = t.wb_rw;
    mem_regwrite = t.mem_regwrite; wb_regwrite = t.wb_regwrite;

    if (t.rst) begin
      m = empty_state();
      mcnt = '0;
    end
    hazard = t.valid && m.valid && m.ctrl[1] && m.rw != 0 &&
             (t.ra == m.rw || t.rb == m.rw) && !t.flush && !t.halt;
    e.s = m; e.stall = hazard; e.cnt = mcnt;
    e.fa = fwd_model(m.valid, m.ra, t);
    e.fb = fwd_model(m.valid, m.rb, t);
    sb.push_back(e);

    if (!t.rst && !t.halt) begin
      if (t.flush || hazard) begin
        m = empty_state();
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end else begin
        m.valid = t.valid; m.pc = t.pc; m.imm = t.imm; m.r1 = t.r1; m.r2 = t.r2;
        m.ra = t.ra; m.rb = t.rb; m.rw = t.rw;
        m.ctrl = t.valid ? t.ctrl : 16'h0000;
      end
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare against the oldest prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ex_valid", 64'(ex_valid), 64'(e.s.valid));
        check("ex_pc",    64'(ex_pc),    64'(e.s.pc));
        check("ex_imm",   64'(ex_imm),   64'(e.s.imm));
        check("ex_r1",    64'(ex_r1),    64'(e.s.r1));
        check("ex_r2",    64'(ex_r2),    64'(e.s.r2));
        check("ex_ra",    64'(ex_ra),    64'(e.s.ra));
        check("ex_rb",    64'(ex_rb),    64'(e.s.rb));
        check("ex_rw",    64'(ex_rw),    64'(e.s.rw));
        check("ex_ctrl",  64'(ex_ctrl),  64'(e.s.ctrl));
        check("stall",    64'(stall),    64'(e.stall));
        check("fwd_a",    64'(fwd_a),    64'(e.fa));
        check("fwd_b",    64'(fwd_b),    64'(e.fb));
`ifdef BUBBLE_CNT_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
`endif
      end
    end
  end

  initial begin : driver
    stim_t t, lw, add;
    m = empty_state();
    mcnt = '0;
    t = nop(); t.rst = 1; step(t);
    t = nop(); step(t);

    // Load-use: lw r8, then add reading r8 stalls once, then forwards from EX/MEM.
    lw = nop(); lw.valid = 1; lw.ctrl = 16'h0003; lw.rw = 5'd8; lw.pc = 32'h100;
    add = nop(); add.valid = 1; add.ctrl = 16'h0001; add.ra = 5'd8; add.rb = 5'd9;
    add.rw = 5'd10; add.pc = 32'h104;
    step(lw);
    step(add);
    step(add);
    t = add; t.mem_rw = 5'd8; t.mem_regwrite = 1; step(t);

    // Forward priority on operand B.
    t = nop(); t.valid = 1; t.ctrl = 16'h0001; t.rb = 5'd5; t.rw = 5'd6; step(t);
    t.mem_rw = 5'd5; t.wb_rw = 5'd5; t.mem_regwrite = 1; t.wb_regwrite = 1; step(t);
    t.mem_regwrite = 0; step(t);

    // Register zero: lw to r0 never stalls; r0 never forwards.
    t = nop(); t.valid = 1; t.ctrl = 16'h0003; t.rw = 5'd0; step(t);
    t = nop(); t.valid = 1; t.ctrl = 16'h0001; t.rw = 5'd3;
    t.mem_rw = 5'd0; t.mem_regwrite = 1; t.wb_rw = 5'd0; t.wb_regwrite = 1; step(t);
    step(t);

    // Flush overrides a pending load-use stall.
    step(lw);
    t = add; t.flush = 1; step(t);
    t = nop(); step(t);

    // Halt for three cycles with changing decode inputs, then release.
    t = nop(); t.valid = 1; t.ctrl = 16'h0005; t.ra = 5'd1; t.rw = 5'd2; t.pc = 32'h200; step(t);
    for (int i = 0; i < 3; i++) begin
      t = rand_stim(); t.rst = 0; t.halt = 1; t.flush = 0; step(t);
    end
    t = nop(); t.valid = 1; t.ctrl = 16'h0009; t.ra = 5'd3; t.rw = 5'd4; t.pc = 32'h300;
    t.imm = 32'h1234; step(t);
    step(nop());

    // Asynchronous reset in the middle of traffic.
    step(lw);
    t = lw; t.rst = 1; step(t);
    step(nop());

    for (int i = 0; i < 400; i++) step(rand_stim());

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
